commu_rx_chk: RTL and testbench
===============================

COMMU_RX_CHK -- requirements
Module: commu_rx_chk

Interface
REQ-001 Parameter: CNT_W, default 32, width of the received-byte counter.
REQ-002 clk_sys  input  1  system clock; all logic SHALL be single-clock on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 rx  input  1  serial line, asynchronous to clk_sys, idle high.
REQ-005 tbit_cyc  input  16  clk_sys cycles per bit.
REQ-006 rx_pattern  input  1  0 = fixed 0x55 expected, 1 = incrementing data expected.
REQ-007 clr  input  1  synchronous clear of counters, sticky flag and pattern reference.
REQ-008 rx_byte  output  8  last received data byte.
REQ-009 rx_vld  output  1  one-cycle pulse when rx_byte is updated.
REQ-010 rx_total  output  CNT_W  count of good-framed bytes.
REQ-011 rx_error  output  1  sticky error flag.
REQ-012 now_recv  output  1  high while a frame is in progress (state != IDLE).
REQ-013 err_cnt  output  16  error count (see Configuration).

Function
REQ-014 Frame SHALL be 8N1: start 0, 8 data bits LSB first, stop 1.
REQ-015 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-016 tbit_cyc SHALL be latched at start-bit detection; values below 4 treated as 4; mid-frame changes ignored.
REQ-017 FSM states: IDLE, START, DATA, STOP, WAIT_HI.
REQ-018 IDLE -> START on synchronized high-to-low edge; bit counter loaded for half-bit (tbit_cyc>>1).
REQ-019 START: at half-bit sample, rx = 0 -> DATA with full-bit counter; rx = 1 -> IDLE (glitch, no error, no count).
REQ-020 DATA: 8 samples, each one full bit period after the previous, shifted in LSB first; after 8th -> STOP.
REQ-021 STOP: sample one bit later; rx = 1 -> IDLE with good frame; rx = 0 -> WAIT_HI with framing error.
REQ-022 WAIT_HI -> IDLE only after synchronized rx = 1 for one cycle (break/stuck-low handling).
REQ-023 On good frame: rx_byte updated and rx_vld pulsed in the cycle after the stop sample; rx_total increments in that same cycle.
REQ-024 rx_total SHALL saturate at all-ones, not wrap.
REQ-025 Pattern 0: error if byte != 0x55.
REQ-026 Pattern 1: first good byte after reset/clr sets reference without check; each subsequent byte expected reference+1 mod 256 (0xFF -> 0x00 legal); reference SHALL become the received byte even on mismatch.
REQ-027 Pattern mismatch or framing error SHALL set rx_error; it stays set until clr or reset.
REQ-028 Framing-error frames SHALL NOT pulse rx_vld, update rx_byte or count in rx_total.
REQ-029 clr coincident with rx_vld: clr wins; rx_total = 0, rx_error = 0, reference invalid; rx_byte still updates.
REQ-030 clr SHALL NOT affect the FSM; a frame in progress completes normally.

Reset
REQ-031 On rst: FSM = IDLE, synchronizer flops = 1, rx_byte = 0x00, rx_vld = 0, rx_total = 0, rx_error = 0, now_recv = 0, err_cnt = 0, reference invalid.
REQ-032 rst asserted mid-frame SHALL abort the frame with no count or error; after release, the next falling edge starts a new frame.

Configuration
REQ-033 Macro RX_ERR_CNT_EN defined: err_cnt increments by 1 per framing or pattern error (an error both framing and pattern counts once), saturates at 0xFFFF, cleared by clr/rst.
REQ-034 Macro RX_ERR_CNT_EN undefined: err_cnt tied to 0, no counter logic; all other behaviour identical.

Verification
REQ-035 tbit_cyc=20, pattern 0, send 100 frames of 0x55 -> rx_total=100, rx_error=0, 100 rx_vld pulses, rx_byte=0x55.
REQ-036 pattern 1, send 0xFE,0xFF,0x00,0x01 then 0x03 -> rx_total=5, rx_error set after 0x03 only, err_cnt=1 (macro on) / 0 (off).
REQ-037 Frame 0x55 with stop bit 0, then rx held low 100 cycles, then one good 0x55 -> rx_total=1, rx_error=1, FSM passes WAIT_HI, no rx_vld for bad frame.
REQ-038 rx low pulse of 5 cycles at tbit_cyc=20 -> no rx_vld, rx_error=0, now_recv returns 0 at half-bit.
REQ-039 rst pulsed during bit 4 of a frame, then good 0x55 -> rx_total=1; clr coincident with rx_vld -> rx_total=0, rx_error=0.
REQ-040 tbit_cyc=2 programmed, frames sent at 4 cycles/bit -> all bytes received correctly; rx_total preset near all-ones (CNT_W=4, 20 frames) -> holds at 15.

Source files
------------

// File: rtl/commu_rx_chk.sv
// 8N1 serial receiver with received-data pattern checker (fixed 0x55 or incrementing).
// Optional error counter enabled by defining RX_ERR_CNT_EN; otherwise err_cnt reads 0.
module commu_rx_chk #(
    parameter int CNT_W = 32
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             rx,
    input  logic [15:0]      tbit_cyc,
    input  logic             rx_pattern,
    input  logic             clr,
    output logic [7:0]       rx_byte,
    output logic             rx_vld,
    output logic [CNT_W-1:0] rx_total,
    output logic             rx_error,
    output logic             now_recv,
    output logic [15:0]      err_cnt
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t           state_q, state_d;
    logic             rx_s1_q, rx_s2_q, rx_s3_q;
    logic [15:0]      tbit_q, tbit_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_vld_q, rx_vld_d;
    logic [CNT_W-1:0] rx_total_q, rx_total_d;
    logic             rx_error_q, rx_error_d;
    logic [7:0]       ref_q, ref_d;
    logic             ref_vld_q, ref_vld_d;
    logic [15:0]      tbit_eff;
    logic             good_frame;
    logic             frame_err;
    logic             pat_err;

    // rx_s3_q is the previous synchronized sample, used only for falling-edge detection
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    assign tbit_eff = (tbit_cyc < 16'd4) ? 16'd4 : tbit_cyc;

    always_comb begin
        state_d    = state_q;
        tbit_d     = tbit_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        rx_byte_d  = rx_byte_q;
        rx_vld_d   = 1'b0;
        rx_total_d = rx_total_q;
        rx_error_d = rx_error_q;
        ref_d      = ref_q;
        ref_vld_d  = ref_vld_q;
        good_frame = 1'b0;
        frame_err  = 1'b0;
        pat_err    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_s3_q && !rx_s2_q) begin
                    state_d = START;
                    tbit_d  = tbit_eff;
                    cnt_d   = (tbit_eff >> 1) - 16'd1;
                end
            end
            START: begin
                if (cnt_q == 16'd0) begin
                    if (!rx_s2_q) begin
                        state_d = DATA;
                        cnt_d   = tbit_q - 16'd1;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == 16'd0) begin
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    cnt_d   = tbit_q - 16'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == 16'd0) begin
                    if (rx_s2_q) begin
                        state_d    = IDLE;
                        good_frame = 1'b1;
                    end else begin
                        state_d   = WAIT_HI;
                        frame_err = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            WAIT_HI: begin
                if (rx_s2_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (good_frame) begin
            rx_vld_d  = 1'b1;
            rx_byte_d = shift_q;
            if (rx_total_q != {CNT_W{1'b1}}) begin
                rx_total_d = rx_total_q + CNT_W'(1);
            end
            if (rx_pattern) begin
                pat_err = ref_vld_q && (shift_q != ref_q + 8'd1);
            end else begin
                pat_err = (shift_q != 8'h55);
            end
            // Reference follows the received byte even on mismatch so one bad byte flags once
            ref_d     = shift_q;
            ref_vld_d = 1'b1;
        end

        if (frame_err || pat_err) begin
            rx_error_d = 1'b1;
        end

        if (clr) begin
            rx_total_d = '0;
            rx_error_d = 1'b0;
            ref_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tbit_q     <= 16'd4;
            cnt_q      <= 16'd0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            rx_byte_q  <= 8'h00;
            rx_vld_q   <= 1'b0;
            rx_total_q <= '0;
            rx_error_q <= 1'b0;
            ref_q      <= 8'h00;
            ref_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tbit_q     <= tbit_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_vld_q   <= rx_vld_d;
            rx_total_q <= rx_total_d;
            rx_error_q <= rx_error_d;
            ref_q      <= ref_d;
            ref_vld_q  <= ref_vld_d;
        end
    end

`ifdef RX_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // A frame is either framing-bad or pattern-checked, so each bad frame counts once
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((frame_err || pat_err) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
        if (clr) begin
            err_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 16'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 16'd0;
`endif

    assign rx_byte  = rx_byte_q;
    assign rx_vld   = rx_vld_q;
    assign rx_total = rx_total_q;
    assign rx_error = rx_error_q;
    assign now_recv = (state_q != IDLE);

endmodule

// File: tb/tb_commu_rx_chk.sv
// Directed bench for commu_rx_chk: scoreboard of expected bytes popped on each rx_vld.
// A second instance with CNT_W=4 shares the inputs to exercise rx_total saturation.
module tb_commu_rx_chk;

`ifdef RX_ERR_CNT_EN
    localparam int ERR_ONE = 1;
`else
    localparam int ERR_ONE = 0;
`endif

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic [15:0] tbit_cyc = 16'd20;
    logic        rx_pattern = 1'b0;
    logic        clr = 1'b0;

    logic [7:0]  rx_byte, rx_byte4;
    logic        rx_vld, rx_vld4;
    logic [31:0] rx_total;
    logic [3:0]  rx_total4;
    logic        rx_error, rx_error4;
    logic        now_recv, now_recv4;
    logic [15:0] err_cnt, err_cnt4;

    int checks = 0;
    int failures = 0;
    int vld_count = 0;
    int v0;
    logic seen;
    logic [7:0] exp_q[$];

    commu_rx_chk #(.CNT_W(32)) dut (
        .clk_sys(clk_sys), .rst(rst), .rx(rx), .tbit_cyc(tbit_cyc),
        .rx_pattern(rx_pattern), .clr(clr), .rx_byte(rx_byte), .rx_vld(rx_vld),
        .rx_total(rx_total), .rx_error(rx_error), .now_recv(now_recv), .err_cnt(err_cnt)
    );

    commu_rx_chk #(.CNT_W(4)) dut4 (
        .clk_sys(clk_sys), .rst(rst), .rx(rx), .tbit_cyc(tbit_cyc),
        .rx_pattern(rx_pattern), .clr(clr), .rx_byte(rx_byte4), .rx_vld(rx_vld4),
        .rx_total(rx_total4), .rx_error(rx_error4), .now_recv(now_recv4), .err_cnt(err_cnt4)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (rx_vld === 1'b1) begin
            vld_count++;
            if (exp_q.size() == 0) begin
                chk("vld_with_empty_scoreboard", exp_q.size(), 1);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("rx_byte", {24'd0, rx_byte}, {24'd0, e});
                $display("rx_vld byte=%02h expected=%02h total=%0d", rx_byte, e, rx_total);
            end
        end
    end

    // Leaves rx at the stop-bit level when done
    task automatic send_frame(input logic [7:0] b, input logic stop, input int cyc);
        @(negedge clk_sys) rx = 1'b0;
        repeat (cyc) @(negedge clk_sys);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (cyc) @(negedge clk_sys);
        end
        rx = stop;
        repeat (cyc) @(negedge clk_sys);
    endtask

    task automatic send_good(input logic [7:0] b, input int cyc);
        exp_q.push_back(b);
        send_frame(b, 1'b1, cyc);
        repeat (2 * cyc) @(negedge clk_sys);
    endtask

    task automatic pulse_clr();
        @(negedge clk_sys) clr = 1'b1;
        @(negedge clk_sys) clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk_sys);
        rst = 1'b0;
        @(negedge clk_sys);
        chk("reset_rx_byte", {24'd0, rx_byte}, 32'h00);
        chk("reset_rx_vld", {31'd0, rx_vld}, 32'd0);
        chk("reset_rx_total", rx_total, 32'd0);
        chk("reset_rx_error", {31'd0, rx_error}, 32'd0);
        chk("reset_now_recv", {31'd0, now_recv}, 32'd0);
        chk("reset_err_cnt", {16'd0, err_cnt}, 32'd0);

        // 100 frames of 0x55, fixed pattern
        v0 = vld_count;
        for (int i = 0; i < 100; i++) send_good(8'h55, 20);
        chk("p0_total", rx_total, 32'd100);
        chk("p0_error", {31'd0, rx_error}, 32'd0);
        chk("p0_vld_pulses", vld_count - v0, 32'd100);
        chk("p0_last_byte", {24'd0, rx_byte}, 32'h55);

        // Incrementing pattern with 0xFF->0x00 wrap, then a skipped value
        rx_pattern = 1'b1;
        pulse_clr();
        send_good(8'hFE, 20);
        send_good(8'hFF, 20);
        send_good(8'h00, 20);
        send_good(8'h01, 20);
        chk("p1_no_error_before_skip", {31'd0, rx_error}, 32'd0);
        send_good(8'h03, 20);
        chk("p1_error_after_skip", {31'd0, rx_error}, 32'd1);
        chk("p1_total", rx_total, 32'd5);
        chk("p1_err_cnt", {16'd0, err_cnt}, ERR_ONE);

        // Framing error then stuck low: receiver must wait for line high
        rx_pattern = 1'b0;
        pulse_clr();
        v0 = vld_count;
        send_frame(8'h55, 1'b0, 20);
        repeat (100) @(negedge clk_sys);
        chk("break_now_recv_held", {31'd0, now_recv}, 32'd1);
        chk("break_error", {31'd0, rx_error}, 32'd1);
        chk("break_no_vld", vld_count - v0, 32'd0);
        chk("break_total", rx_total, 32'd0);
        rx = 1'b1;
        repeat (5) @(negedge clk_sys);
        chk("break_released", {31'd0, now_recv}, 32'd0);
        send_good(8'h55, 20);
        chk("break_then_good_total", rx_total, 32'd1);
        chk("break_error_sticky", {31'd0, rx_error}, 32'd1);
        chk("break_err_cnt", {16'd0, err_cnt}, ERR_ONE);

        // 5-cycle glitch rejected at the half-bit sample
        pulse_clr();
        v0 = vld_count;
        @(negedge clk_sys) rx = 1'b0;
        repeat (5) @(negedge clk_sys);
        rx = 1'b1;
        chk("glitch_now_recv_start", {31'd0, now_recv}, 32'd1);
        repeat (15) @(negedge clk_sys);
        chk("glitch_now_recv_end", {31'd0, now_recv}, 32'd0);
        chk("glitch_error", {31'd0, rx_error}, 32'd0);
        chk("glitch_no_vld", vld_count - v0, 32'd0);

        // Reset in the middle of data bit 4 aborts the frame
        @(negedge clk_sys) rx = 1'b0;
        repeat (20) @(negedge clk_sys);
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0);
            repeat (20) @(negedge clk_sys);
        end
        rx = 1'b1;
        repeat (10) @(negedge clk_sys);
        rst = 1'b1;
        repeat (2) @(negedge clk_sys);
        rst = 1'b0;
        @(negedge clk_sys);
        chk("midrst_total", rx_total, 32'd0);
        chk("midrst_now_recv", {31'd0, now_recv}, 32'd0);
        chk("midrst_error", {31'd0, rx_error}, 32'd0);
        send_good(8'h55, 20);
        chk("midrst_good_total", rx_total, 32'd1);

        // clr coincident with rx_vld wins over the count and the sticky flag
        send_good(8'h12, 20);
        chk("pre_clr_error", {31'd0, rx_error}, 32'd1);
        chk("pre_clr_total", rx_total, 32'd2);
        exp_q.push_back(8'h55);
        seen = 1'b0;
        fork
            send_frame(8'h55, 1'b1, 20);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk_sys);
                    if (rx_vld === 1'b1) begin
                        clr = 1'b1;
                        seen = 1'b1;
                        break;
                    end
                end
                @(negedge clk_sys) clr = 1'b0;
            end
        join
        repeat (40) @(negedge clk_sys);
        chk("clr_vld_seen", {31'd0, seen}, 32'd1);
        chk("clr_vld_total", rx_total, 32'd0);
        chk("clr_vld_error", {31'd0, rx_error}, 32'd0);
        chk("clr_vld_byte", {24'd0, rx_byte}, 32'h55);

        // tbit_cyc below the minimum is raised to 4; small counter saturates
        tbit_cyc = 16'd2;
        rx_pattern = 1'b1;
        pulse_clr();
        for (int b = 0; b < 20; b++) send_good(8'(b), 4);
        chk("fast_total", rx_total, 32'd20);
        chk("fast_error", {31'd0, rx_error}, 32'd0);
        chk("sat_total_cnt4", {28'd0, rx_total4}, 32'd15);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        chk("global_timeout", 32'd1, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
